// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double dabble: one right shift per cycle,
// then every BCD digit >= 8 has 3 subtracted from it. Start/Ready/Done handshake.
module bcd_to_binary #(
    parameter int unsigned N = 32,
    parameter int unsigned D = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [D-1:0][3:0]  BCD,
    output logic [N-1:0]       Binary,
    output logic               Ready,
    output logic               Done,
    output logic               Error,
    output logic               Overflow
);

    localparam int unsigned SW = 4 * D;
    localparam int unsigned CW = $clog2(SW + 1);
    // Working width for the result so the overflow test also covers N >= 4*D.
    localparam int unsigned XW = (N > SW) ? N : SW;
    localparam logic [CW-1:0] LastCnt = CW'(SW - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] digit_q, digit_d;
    logic [SW-1:0] result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  binary_q, binary_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          overflow_q, overflow_d;

    logic [SW-1:0] shifted_digit;
    logic [SW-1:0] shifted_result;
    logic [XW-1:0] result_ext;
    logic          bad_digit;

    function automatic logic has_bad_digit(input logic [D-1:0][3:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(D); i++) begin
            if (v[i] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [SW-1:0] correct_digits(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic [3:0]    nib;
        r = v;
        for (int i = 0; i < int'(D); i++) begin
            nib = v[4*i +: 4];
            if (nib >= 4'd8) r[4*i +: 4] = nib - 4'd3;
        end
        return r;
    endfunction

    assign bad_digit      = has_bad_digit(BCD);
    assign shifted_digit  = {1'b0, digit_q[SW-1:1]};
    assign shifted_result = {digit_q[0], result_q[SW-1:1]};
    assign result_ext     = XW'(shifted_result);

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        binary_d   = binary_q;
        done_d     = 1'b0;
        error_d    = error_q;
        overflow_d = overflow_q;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    if (bad_digit) begin
                        binary_d   = '0;
                        error_d    = 1'b1;
                        overflow_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        digit_d  = BCD;
                        result_d = '0;
                        cnt_d    = '0;
                        state_d  = StShift;
                    end
                end
            end
            StShift: begin
                digit_d  = correct_digits(shifted_digit);
                result_d = shifted_result;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    binary_d   = result_ext[N-1:0];
                    overflow_d = |(result_ext >> N);
                    error_d    = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            digit_q    <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            binary_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            binary_q   <= binary_d;
            done_q     <= done_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
        end
    end

    assign Ready    = (state_q == StIdle);
    assign Binary   = binary_q;
    assign Done     = done_q;
    assign Error    = error_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed vector table, hand sequences for
// mid-conversion Start/Reset and back-to-back, plus random operands against a decimal model.
module tb_bcd_to_binary;

    logic             Clock;
    logic             Reset;
    logic             Start;
    logic [9:0][3:0]  BCD;
    logic [31:0]      Binary;
    logic             Ready;
    logic             Done;
    logic             Error;
    logic             Overflow;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_binary #(.N(32), .D(10)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .BCD      (BCD),
        .Binary   (Binary),
        .Ready    (Ready),
        .Done     (Done),
        .Error    (Error),
        .Overflow (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [39:0] bcd;
        logic [31:0] bin;
        logic        err;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] to_bcd(input longint unsigned v);
        logic [39:0] r;
        longint unsigned x;
        x = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: decimal value of the digits, then reduce to 32 bits.
    task automatic ref_model(input logic [39:0] bcd, output logic [31:0] bin,
                             output logic err, output logic ovf);
        longint unsigned val;
        logic [3:0] d;
        val = 0;
        err = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) err = 1'b1;
            val = val * 10 + longint'(d);
        end
        if (err) begin
            bin = '0;
            ovf = 1'b0;
        end else begin
            bin = val[31:0];
            ovf = (val >= 64'h1_0000_0000);
        end
    endtask

    // lat: edges after the accepting edge until Done; low: samples with Ready=0.
    task automatic convert(input logic [39:0] bcd, output int lat, output int low);
        @(negedge Clock);
        Start = 1'b1;
        BCD   = bcd;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        BCD   = {8'($urandom), 32'($urandom)};
        lat   = 0;
        low   = Ready ? 0 : 1;
        while (!Done && lat < 200) begin
            @(posedge Clock);
            #1;
            lat++;
            if (!Ready) low++;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int lat, low;
        logic [31:0] e_bin;
        logic e_err, e_ovf;
        logic [39:0] op;
        logic seen_done;

        vecs[0] = '{40'h00_0000_0000, 32'h0000_0000, 1'b0, 1'b0, 40};
        vecs[1] = '{40'h42_9496_7295, 32'hFFFF_FFFF, 1'b0, 1'b0, 40};
        vecs[2] = '{40'h00_0000_1234, 32'h0000_04D2, 1'b0, 1'b0, 40};
        vecs[3] = '{40'h42_9496_7296, 32'h0000_0000, 1'b0, 1'b1, 40};
        vecs[4] = '{40'h99_9999_9999, 32'h540B_E3FF, 1'b0, 1'b1, 40};
        vecs[5] = '{40'h00_0000_A000, 32'h0000_0000, 1'b1, 1'b0, 0};
        vecs[6] = '{40'h00_0000_0007, 32'h0000_0007, 1'b0, 1'b0, 40};

        Reset = 1'b1;
        Start = 1'b0;
        BCD   = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_ready", 64'(Ready), 64'd1);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_binary", 64'(Binary), 64'd0);
        check("reset_error", 64'(Error), 64'd0);
        check("reset_overflow", 64'(Overflow), 64'd0);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].bcd, lat, low);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_ready_low", i), 64'(low), 64'(vecs[i].lat));
            check($sformatf("vec%0d_binary", i), 64'(Binary), 64'(vecs[i].bin));
            check($sformatf("vec%0d_error", i), 64'(Error), 64'(vecs[i].err));
            check($sformatf("vec%0d_overflow", i), 64'(Overflow), 64'(vecs[i].ovf));
            @(posedge Clock);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(Done), 64'd0);
        end

        // Start pulsed mid-conversion is ignored.
        @(negedge Clock);
        Start = 1'b1;
        BCD   = to_bcd(12345);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        lat   = 0;
        while (!Done && lat < 200) begin
            if (lat == 10) begin
                Start = 1'b1;
                BCD   = to_bcd(99);
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock);
            #1;
            lat++;
        end
        Start = 1'b0;
        check("ignore_start_latency", 64'(lat), 64'd40);
        check("ignore_start_binary", 64'(Binary), 64'h3039);

        // Reset aborts a conversion in progress without a Done.
        @(negedge Clock);
        Start = 1'b1;
        BCD   = to_bcd(12345);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (20) @(posedge Clock);
        #1;
        check("abort_busy", 64'(Ready), 64'd0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("abort_ready", 64'(Ready), 64'd1);
        check("abort_binary", 64'(Binary), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_error", 64'(Error), 64'd0);
        check("abort_overflow", 64'(Overflow), 64'd0);
        seen_done = 1'b0;
        repeat (60) begin
            @(posedge Clock);
            #1;
            if (Done) seen_done = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        // Start held high: one idle cycle between back-to-back conversions.
        @(negedge Clock);
        Start = 1'b1;
        BCD   = to_bcd(12345);
        @(posedge Clock);
        #1;
        lat = 0;
        while (!Done && lat < 200) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        check("b2b_first_latency", 64'(lat), 64'd40);
        check("b2b_first_binary", 64'(Binary), 64'h3039);
        check("b2b_idle_gap", 64'(Ready), 64'd1);
        BCD = to_bcd(99);
        @(posedge Clock);
        #1;
        check("b2b_second_accept", 64'(Ready), 64'd0);
        lat = 0;
        while (!Done && lat < 200) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        Start = 1'b0;
        check("b2b_second_latency", 64'(lat), 64'd40);
        check("b2b_second_binary", 64'(Binary), 64'h63);

        // Random operands: loopback of random 32-bit values, wide decimals, raw nibbles.
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 2))
                0: op = to_bcd(longint'($urandom));
                1: op = to_bcd({32'($urandom), 32'($urandom)} % 64'd10000000000);
                default: op = {8'($urandom), 32'($urandom)};
            endcase
            ref_model(op, e_bin, e_err, e_ovf);
            convert(op, lat, low);
            check($sformatf("rnd%0d_latency", k), 64'(lat), e_err ? 64'd0 : 64'd40);
            check($sformatf("rnd%0d_binary", k), 64'(Binary), 64'(e_bin));
            check($sformatf("rnd%0d_error", k), 64'(Error), 64'(e_err));
            check($sformatf("rnd%0d_overflow", k), 64'(Overflow), 64'(e_ovf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per cycle, then subtract 3 from each BCD digit that is >= 8.
- Inverse of the team's DoubleDabble binary-to-BCD block. Uses the same Start/Ready handshake style so the two can be chained in loopback benches.
- Takes D packed BCD digits and returns an N-bit unsigned binary value, with invalid-digit and overflow flags.

Parameters:
- N, 32, width of the binary result.
- D, 10, number of BCD input digits. The shift register holds 4*D bits.

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a conversion; sampled only while Ready=1.
- BCD  input  [D-1:0][3:0]  packed BCD operand; digit 0 is least significant; sampled on the accepting edge only.
- Binary  output  N  converted value; registered; held until the next completion.
- Ready  output  1  high when idle and able to accept Start.
- Done  output  1  one-cycle pulse when Binary/Error/Overflow are updated.
- Error  output  1  last accepted operand contained a digit > 9.
- Overflow  output  1  last converted value exceeded 2^N-1.

Behaviour:
- Reset (edge with Reset=1):
  - State goes to IDLE.
  - Binary=0, Ready=1, Done=0, Error=0, Overflow=0.
  - Shift register and counter are cleared.
  - Reset wins over Start and aborts any conversion in progress; no Done is produced for an aborted conversion.
- States:
  - IDLE: Ready=1.
  - SHIFT: Ready=0.
- IDLE, Start=1, all digits <= 9 (accepting edge E0):
  - Load BCD into the 4*D-bit digit register.
  - Clear the 4*D-bit result register and the counter.
  - Go to SHIFT; Ready=0 from E0.
- IDLE, Start=1, any digit > 9:
  - No conversion; stay in IDLE; Ready stays 1.
  - At E0: Error=1, Binary=0, Overflow=0, Done=1 for one cycle.
- SHIFT, each edge:
  - Shift the concatenation {digit register, result register} right by one; a 0 enters the digit MSB.
  - Then, for every digit of the shifted digit register with value >= 8, subtract 3 from it. All digits are corrected in parallel in the same cycle.
  - Increment the counter.
- SHIFT, on the 4*D-th shift edge (E4D):
  - Use the post-shift result register as the full result.
  - Binary = low N bits of the result.
  - Overflow = 1 if any result bit at index >= N is nonzero. Overflow is always 0 when N >= 4*D.
  - Error=0, Done=1 for one cycle, Ready=1, return to IDLE.
- Latency:
  - Valid operand: exactly 4*D cycles from the accepting edge to Ready/Done.
  - Invalid operand: 1 cycle.
- Start while Ready=0 is ignored. BCD changes during SHIFT have no effect.
- Back-to-back: Start held high is accepted on the edge after Done, giving a 1-cycle IDLE gap between conversions.
- Done is 0 on every edge except a completion edge.
- Error and Overflow hold their value until the next completion or Reset.
- Counter width is $clog2(4*D+1).
- No combinational paths from inputs to outputs.

Test Plan:
All scenarios use defaults N=32, D=10.
1. Reset 2 cycles, then Start with BCD=0 -> Ready low for exactly 40 cycles, then Done pulse, Binary=0, Error=0, Overflow=0.
2. BCD=4294967295 -> after 40 cycles Binary=32'hFFFFFFFF, Overflow=0; also 0000001234 -> 32'h000004D2.
3. BCD=4294967296 -> Binary=32'h00000000, Overflow=1; 9999999999 -> Binary=32'h540BE3FF, Overflow=1.
4. BCD digit 3 = 4'hA, others 0 -> next edge: Done=1, Error=1, Binary=0; Ready never drops. A following valid Start of 0000000007 -> Binary=7, Error cleared.
5. Start 0000012345. At cycle 10, pulse Start with 0000000099 -> ignored; result is 32'h00003039 at cycle 40. New Start, Reset asserted at cycle 20 -> next edge Ready=1, all outputs 0, no Done.
6. Start held high with BCD=0000012345, then 0000000099 -> Binary 32'h3039, then 32'h63. Each takes 40 cycles, with exactly one IDLE cycle between them. A loopback through DoubleDabble of random V returns V.
